// File: rtl/y_rf_scoreboard_if.sv
// Operand-read, writeback and issue signals shared by the register file/scoreboard and its client.
// The slave modport is the register file's view.
interface y_rf_scoreboard_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 5
);
    logic [AW-1:0]    rs1;
    logic [AW-1:0]    rs2;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             iss_en;
    logic [AW-1:0]    iss_rd;
    logic             busy1;
    logic             busy2;
    logic             stall;
    logic [AW:0]      pend_cnt;

    modport master (
        output rs1, rs2, wr_en, wr_addr, wr_data, iss_en, iss_rd,
        input  rd1, rd2, busy1, busy2, stall, pend_cnt
    );

    modport slave (
        input  rs1, rs2, wr_en, wr_addr, wr_data, iss_en, iss_rd,
        output rd1, rd2, busy1, busy2, stall, pend_cnt
    );
endinterface

// File: rtl/y_rf_scoreboard.sv
// Execute-stage register file with write-to-read bypass and a per-register
// pending scoreboard that stalls issue while an operand has an in-flight producer.
module y_rf_scoreboard #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned AW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    y_rf_scoreboard_if.slave bus
);
    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic [NREG-1:0]  pending_q, pending_d;
    logic [AW:0]      pend_cnt_q, pend_cnt_d;

    logic             wr_hit, iss_acc;
    logic             byp1, byp2;
    logic             busy1, busy2, stall;
    logic             cnt_inc, cnt_dec;
    logic [WIDTH-1:0] rd1, rd2;

    always_comb begin
        byp1  = bus.wr_en && (bus.wr_addr == bus.rs1);
        byp2  = bus.wr_en && (bus.wr_addr == bus.rs2);
        busy1 = (bus.rs1 != '0) && pending_q[bus.rs1] && !byp1;
        busy2 = (bus.rs2 != '0) && pending_q[bus.rs2] && !byp2;
        stall = busy1 | busy2;

        rd1 = '0;
        if (bus.rs1 != '0) rd1 = byp1 ? bus.wr_data : regs_q[bus.rs1];
        rd2 = '0;
        if (bus.rs2 != '0) rd2 = byp2 ? bus.wr_data : regs_q[bus.rs2];
    end

    always_comb begin
        wr_hit  = bus.wr_en && (bus.wr_addr != '0);
        iss_acc = bus.iss_en && !stall && (bus.iss_rd != '0);

        regs_d    = regs_q;
        pending_d = pending_q;
        if (wr_hit) begin
            regs_d[bus.wr_addr]    = bus.wr_data;
            pending_d[bus.wr_addr] = 1'b0;
        end
        // Issue is applied after the write so a new producer to the same register wins.
        if (iss_acc) pending_d[bus.iss_rd] = 1'b1;

        cnt_inc = iss_acc && !pending_q[bus.iss_rd];
        cnt_dec = wr_hit && pending_q[bus.wr_addr] &&
                  !(iss_acc && (bus.iss_rd == bus.wr_addr));
        pend_cnt_d = pend_cnt_q + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
            pending_q  <= '0;
            pend_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            pending_q  <= pending_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign bus.rd1      = rd1;
    assign bus.rd2      = rd2;
    assign bus.busy1    = busy1;
    assign bus.busy2    = busy2;
    assign bus.stall    = stall;
    assign bus.pend_cnt = pend_cnt_q;
endmodule

// File: tb/tb_y_rf_scoreboard.sv
// Directed-vector bench for y_rf_scoreboard: stimulus queues hand-computed
// expectations, a negedge monitor pops and compares them against the DUT outputs.
module tb_y_rf_scoreboard;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned AW    = 5;

    typedef struct {
        string       name;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        busy1;
        logic        busy2;
        logic        stall;
        logic [5:0]  cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    y_rf_scoreboard_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    y_rf_scoreboard #(.WIDTH(WIDTH), .NREG(32), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [70:0] act, req;
            e   = exp_q.pop_front();
            act = {bus.rd1, bus.rd2, bus.busy1, bus.busy2, bus.stall, bus.pend_cnt};
            req = {e.rd1, e.rd2, e.busy1, e.busy2, e.stall, e.cnt};
            tests_run++;
            if (act !== req) begin
                tests_failed++;
                $display("FAIL %s: got rd1=%h rd2=%h b1=%b b2=%b st=%b cnt=%0d, want rd1=%h rd2=%h b1=%b b2=%b st=%b cnt=%0d",
                         e.name, bus.rd1, bus.rd2, bus.busy1, bus.busy2, bus.stall, bus.pend_cnt,
                         e.rd1, e.rd2, e.busy1, e.busy2, e.stall, e.cnt);
            end
        end
    end

    task automatic set_in(input logic [4:0] r1, input logic [4:0] r2,
                          input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic ie, input logic [4:0] ir);
        bus.rs1 = r1;  bus.rs2 = r2;
        bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
        bus.iss_en = ie; bus.iss_rd = ir;
    endtask

    // Queue the expectation for the current cycle, then advance past the next edge.
    task automatic expect_step(input string n, input logic [31:0] e1, input logic [31:0] e2,
                               input logic b1, input logic b2, input logic st, input logic [5:0] c);
        exp_t e;
        e.name = n; e.rd1 = e1; e.rd2 = e2;
        e.busy1 = b1; e.busy2 = b2; e.stall = st; e.cnt = c;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        expect_step("reset_state", 0, 0, 0, 0, 0, 0);

        // Async reset mid-cycle after reg5 write and an issue to reg6
        set_in(5, 0, 1, 5, 32'h12345678, 0, 0);
        expect_step("wr5_bypass", 32'h12345678, 0, 0, 0, 0, 0);
        set_in(5, 0, 0, 0, 0, 1, 6);
        expect_step("rd5_pre_reset", 32'h12345678, 0, 0, 0, 0, 0);
        set_in(5, 6, 0, 0, 0, 0, 0);
        #1 reset = 1'b1;
        expect_step("async_reset", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        set_in(5, 6, 0, 0, 0, 0, 0);
        expect_step("post_reset", 0, 0, 0, 0, 0, 0);

        // Write/read and x0
        set_in(3, 0, 1, 3, 32'hDEADBEEF, 0, 0);
        expect_step("wr3", 32'hDEADBEEF, 0, 0, 0, 0, 0);
        set_in(3, 0, 1, 0, 32'hFFFFFFFF, 0, 0);
        expect_step("wr0_rs2_zero", 32'hDEADBEEF, 0, 0, 0, 0, 0);
        set_in(3, 0, 0, 0, 0, 0, 0);
        expect_step("rd3_after_x0", 32'hDEADBEEF, 0, 0, 0, 0, 0);

        // Bypass
        set_in(0, 0, 1, 7, 32'h1, 0, 0);
        expect_step("wr7_one", 0, 0, 0, 0, 0, 0);
        set_in(7, 7, 0, 0, 0, 0, 0);
        expect_step("rd7_one", 32'h1, 32'h1, 0, 0, 0, 0);
        set_in(7, 7, 1, 7, 32'h55AA55AA, 0, 0);
        expect_step("bypass7", 32'h55AA55AA, 32'h55AA55AA, 0, 0, 0, 0);
        set_in(7, 7, 0, 0, 0, 0, 0);
        expect_step("rd7_after", 32'h55AA55AA, 32'h55AA55AA, 0, 0, 0, 0);

        // Scoreboard basics
        set_in(9, 0, 0, 0, 0, 1, 9);
        expect_step("iss9", 0, 0, 0, 0, 0, 0);
        set_in(9, 0, 0, 0, 0, 1, 10);
        expect_step("iss10_stalled", 0, 0, 1, 0, 1, 1);
        set_in(9, 0, 0, 0, 0, 0, 0);
        expect_step("cnt_after_refuse", 0, 0, 1, 0, 1, 1);
        set_in(10, 9, 0, 0, 0, 0, 0);
        expect_step("r10_not_pending", 0, 0, 0, 1, 1, 1);
        set_in(9, 0, 1, 9, 32'h42, 0, 0);
        expect_step("wr9_resolves", 32'h42, 0, 0, 0, 0, 1);
        set_in(9, 0, 0, 0, 0, 0, 0);
        expect_step("cnt_cleared", 32'h42, 0, 0, 0, 0, 0);

        // Simultaneous write and issue to pending reg4
        set_in(0, 0, 0, 0, 0, 1, 4);
        expect_step("iss4", 0, 0, 0, 0, 0, 0);
        set_in(4, 0, 1, 4, 32'hCAFEF00D, 1, 4);
        expect_step("wr_iss4", 32'hCAFEF00D, 0, 0, 0, 0, 1);
        set_in(4, 0, 0, 0, 0, 0, 0);
        expect_step("reg4_still_pend", 32'hCAFEF00D, 0, 1, 0, 1, 1);
        set_in(4, 0, 1, 4, 32'h77, 0, 0);
        expect_step("wr4_clear", 32'h77, 0, 0, 0, 0, 1);
        set_in(0, 4, 0, 0, 0, 0, 0);
        expect_step("rd4_cnt0", 0, 32'h77, 0, 0, 0, 0);

        // Re-issue to a pending register
        set_in(0, 0, 0, 0, 0, 1, 8);
        expect_step("iss8", 0, 0, 0, 0, 0, 0);
        set_in(0, 0, 0, 0, 0, 1, 8);
        expect_step("reiss8", 0, 0, 0, 0, 0, 1);
        set_in(0, 8, 0, 0, 0, 0, 0);
        expect_step("reiss8_cnt", 0, 0, 0, 1, 1, 1);

        // Issue/write to different registers in one cycle: net zero
        set_in(0, 0, 1, 8, 32'h0, 1, 2);
        expect_step("wr8_iss2", 0, 0, 0, 0, 0, 1);
        set_in(2, 8, 0, 0, 0, 0, 0);
        expect_step("net_zero", 0, 0, 1, 0, 1, 1);
        set_in(0, 0, 1, 2, 32'h0, 0, 0);
        expect_step("wr2", 0, 0, 0, 0, 0, 1);
        set_in(0, 0, 0, 0, 0, 0, 0);
        expect_step("idle_cnt0", 0, 0, 0, 0, 0, 0);

        // Counter sweep
        for (int i = 1; i < 32; i++) begin
            set_in(0, 0, 0, 0, 0, 1, 5'(i));
            expect_step("cnt_up", 0, 0, 0, 0, 0, 6'(i - 1));
        end
        set_in(0, 0, 0, 0, 0, 1, 0);
        expect_step("cnt_full", 0, 0, 0, 0, 0, 31);
        set_in(0, 0, 0, 0, 0, 0, 0);
        expect_step("iss_x0_no_effect", 0, 0, 0, 0, 0, 31);
        for (int i = 1; i < 32; i++) begin
            set_in(5'(i), 0, 1, 5'(i), 32'(i) * 32'h01010101, 0, 0);
            expect_step("cnt_down", 32'(i) * 32'h01010101, 0, 0, 0, 0, 6'(32 - i));
        end
        set_in(31, 3, 0, 0, 0, 0, 0);
        expect_step("cnt_empty", 32'h1F1F1F1F, 32'h03030303, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
